bit_enable_writer: RTL and testbench

Serial write sequencer for a bank of independently enabled single-bit registers: accepts a WIDTH-bit word over a valid/ready handshake and writes it one bit per cycle by driving a one-hot enable vector plus a shared data bit. It is the writer side of the per-bit-enable register arrays used as clock-gating test structures. Each register bit is loaded only in its own enable cycle, so downstream gating cells see sparse, predictable enable activity.

---
 rtl/bit_enable_writer.sv | 73 +++++++
 tb/tb_bit_enable_writer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_enable_writer.sv
// bit_enable_writer: serial one-hot-enable writer for a per-bit-enable register bank.
// Optional SKIP_UNCHANGED_EN suppresses enables for bits equal to the last fully written word.
module bit_enable_writer #(
  parameter int WIDTH = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_ORDER,
  output logic [WIDTH-1:0] EN,
  output logic             D_OUT,
  output logic             BUSY,
  output logic             DONE
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] TOP = IW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, WRITE, FINISH} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [WIDTH-1:0] data, data_n, mask;
  logic order, order_n, last;
  assign last = idx == (order ? '0 : TOP);
  always_comb begin
    state_n = IDLE;
    idx_n = idx;
    data_n = data;
    order_n = order;
    if (state == WRITE) begin
      state_n = last ? FINISH : WRITE;
      idx_n = last ? idx : (order ? idx - 1'b1 : idx + 1'b1);
    end else if (IN_VALID && IN_READY) begin
      state_n = WRITE;
      data_n = IN_DATA;
      order_n = IN_ORDER;
      idx_n = IN_ORDER ? TOP : '0;
    end
  end
`ifdef SKIP_UNCHANGED_EN
  logic [WIDTH-1:0] shadow, shadow_n;
  // compare against the shadow as it will be after this edge, so a word
  // accepted in FINISH sees the word that just completed
  assign shadow_n = (state == FINISH) ? data : shadow;
  assign mask = data_n ^ shadow_n;
  always_ff @(posedge CLK) shadow <= RST ? '0 : shadow_n;
`else
  assign mask = '1;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      idx <= '0;
      data <= '0;
      order <= 1'b0;
      EN <= '0;
      D_OUT <= 1'b0;
      BUSY <= 1'b0;
      DONE <= 1'b0;
      IN_READY <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      data <= data_n;
      order <= order_n;
      EN <= (state_n == WRITE) ? (WIDTH'(1) << idx_n) & mask : '0;
      D_OUT <= (state_n == WRITE) && data_n[idx_n];
      BUSY <= state_n == WRITE;
      DONE <= state_n == FINISH;
      IN_READY <= state_n != WRITE;
    end
  end
endmodule

// File: tb/tb_bit_enable_writer.sv
// tb_bit_enable_writer: scoreboard bench for bit_enable_writer with a modelled register bank.
module tb_bit_enable_writer;
  localparam int W = 5;
  logic CLK = 1'b0, RST = 1'b1, IN_VALID = 1'b0, IN_ORDER = 1'b0;
  logic [W-1:0] IN_DATA = '0;
  logic IN_READY, D_OUT, BUSY, DONE;
  logic [W-1:0] EN;
  typedef struct packed {logic [W-1:0] en; logic d;} slot_t;
  slot_t exp_q[$];
  int n_vec = 0, n_err = 0;
  logic [W-1:0] bank, model_shadow = '0;
  logic bank_clr = 1'b0;

  bit_enable_writer #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
    .IN_ORDER(IN_ORDER), .EN(EN), .D_OUT(D_OUT), .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK)
    if (bank_clr) bank <= '0;
    else for (int i = 0; i < W; i++) if (EN[i]) bank[i] <= D_OUT;

  task automatic push_word(input logic [W-1:0] data, input logic ord);
    for (int k = 0; k < W; k++) begin
      int i;
      slot_t s;
      i = ord ? W - 1 - k : k;
      s.d = data[i];
`ifdef SKIP_UNCHANGED_EN
      s.en = (data[i] != model_shadow[i]) ? W'(1) << i : '0;
`else
      s.en = W'(1) << i;
`endif
      exp_q.push_back(s);
    end
    model_shadow = data;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    bank_clr = 1'b1;
    IN_VALID = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    bank_clr = 1'b0;
    model_shadow = '0;
    exp_q.delete();
  endtask

  task automatic write_word(input string name, input logic [W-1:0] data, input logic ord);
    slot_t s;
    int t = 0;
    while (IN_READY !== 1'b1 && t < 20) begin
      @(negedge CLK);
      t++;
    end
    n_vec++;
    if (IN_READY !== 1'b1) begin
      n_err++;
      $display("FAIL %s ready_wait: IN_READY=%b want 1 within 20 cycles", name, IN_READY);
    end
    IN_VALID = 1'b1;
    IN_DATA = data;
    IN_ORDER = ord;
    push_word(data, ord);
    @(negedge CLK);
    IN_VALID = 1'b0;
    IN_DATA = ~data;
    IN_ORDER = ~ord;
    for (int k = 0; k < W; k++) begin
      s = exp_q.pop_front();
      n_vec++;
      if ({EN, D_OUT, BUSY, IN_READY, DONE} !== {s.en, s.d, 3'b100}) begin
        n_err++;
        $display("FAIL %s slot%0d: EN=%b D=%b BUSY=%b RDY=%b DONE=%b want EN=%b D=%b BUSY=1 RDY=0 DONE=0",
                 name, k, EN, D_OUT, BUSY, IN_READY, DONE, s.en, s.d);
      end
      @(negedge CLK);
    end
    n_vec++;
    if ({DONE, EN, BUSY, IN_READY} !== {1'b1, {W{1'b0}}, 2'b01}) begin
      n_err++;
      $display("FAIL %s finish: DONE=%b EN=%b BUSY=%b RDY=%b want 1 %b 0 1", name, DONE, EN, BUSY, IN_READY, {W{1'b0}});
    end
    n_vec++;
    if (bank !== data) begin
      n_err++;
      $display("FAIL %s bank: got %b want %b", name, bank, data);
    end
    @(negedge CLK);
    n_vec++;
    if ({DONE, BUSY, IN_READY, EN} !== {3'b001, {W{1'b0}}}) begin
      n_err++;
      $display("FAIL %s idle: DONE=%b BUSY=%b RDY=%b EN=%b want 0 0 1 0", name, DONE, BUSY, IN_READY, EN);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bank_clr = 1'b1;
    IN_VALID = 1'b1;
    IN_DATA = '1;
    repeat (2) @(negedge CLK);
    n_vec++;
    if ({EN, D_OUT, DONE, BUSY, IN_READY} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: EN=%b D=%b DONE=%b BUSY=%b RDY=%b want all 0", EN, D_OUT, DONE, BUSY, IN_READY);
    end
    RST = 1'b0;
    bank_clr = 1'b0;
    IN_VALID = 1'b0;
    model_shadow = '0;
    @(negedge CLK);
    n_vec++;
    if ({IN_READY, BUSY, DONE, EN} !== {3'b100, {W{1'b0}}}) begin
      n_err++;
      $display("FAIL reset_release: RDY=%b BUSY=%b DONE=%b EN=%b want 1 0 0 0", IN_READY, BUSY, DONE, EN);
    end
  endtask

  task automatic test_ascending();
    do_reset();
    write_word("ascending", 5'b10110, 1'b0);
  endtask

  task automatic test_descending();
    do_reset();
    write_word("descending", 5'b10110, 1'b1);
  endtask

  task automatic test_back_to_back();
    slot_t s;
    do_reset();
    @(negedge CLK);
    IN_VALID = 1'b1;
    IN_DATA = 5'h1F;
    IN_ORDER = 1'b0;
    push_word(5'h1F, 1'b0);
    @(negedge CLK);
    IN_DATA = 5'h00;
    push_word(5'h00, 1'b0);
    for (int c = 1; c <= 2 * (W + 1); c++) begin
      if (c == 7) IN_VALID = 1'b0;
      n_vec++;
      if (c % (W + 1) == 0) begin
        if ({DONE, EN, IN_READY} !== {1'b1, {W{1'b0}}, 1'b1}) begin
          n_err++;
          $display("FAIL b2b cycle%0d: DONE=%b EN=%b RDY=%b want 1 0 1", c, DONE, EN, IN_READY);
        end
      end else begin
        s = exp_q.pop_front();
        if ({EN, D_OUT, BUSY, IN_READY, DONE} !== {s.en, s.d, 3'b100}) begin
          n_err++;
          $display("FAIL b2b cycle%0d: EN=%b D=%b BUSY=%b RDY=%b DONE=%b want %b %b 1 0 0",
                   c, EN, D_OUT, BUSY, IN_READY, DONE, s.en, s.d);
        end
      end
      @(negedge CLK);
    end
    n_vec++;
    if (bank !== 5'h00 || DONE !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b end: bank=%b DONE=%b pending=%0d want 00000 0 0", bank, DONE, exp_q.size());
    end
  endtask

  task automatic test_reset_abort();
    do_reset();
    @(negedge CLK);
    IN_VALID = 1'b1;
    IN_DATA = 5'b11111;
    IN_ORDER = 1'b0;
    @(negedge CLK);
    IN_VALID = 1'b0;
    n_vec++;
    if (EN !== 5'b00001) begin
      n_err++;
      $display("FAIL abort slot0: EN=%b want 00001", EN);
    end
    @(negedge CLK);
    n_vec++;
    if (EN !== 5'b00010) begin
      n_err++;
      $display("FAIL abort slot1: EN=%b want 00010", EN);
    end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_shadow = '0;
    n_vec++;
    if ({EN, BUSY, DONE, IN_READY} !== '0) begin
      n_err++;
      $display("FAIL abort reset: EN=%b BUSY=%b DONE=%b RDY=%b want all 0", EN, BUSY, DONE, IN_READY);
    end
    @(negedge CLK);
    n_vec++;
    if (IN_READY !== 1'b1) begin
      n_err++;
      $display("FAIL abort ready: RDY=%b want 1", IN_READY);
    end
    for (int c = 0; c < W + 2; c++) begin
      n_vec++;
      if (DONE !== 1'b0 || EN !== '0) begin
        n_err++;
        $display("FAIL abort quiet%0d: DONE=%b EN=%b want 0 0", c, DONE, EN);
      end
      @(negedge CLK);
    end
    n_vec++;
    if (bank !== 5'b00011) begin
      n_err++;
      $display("FAIL abort bank: got %b want 00011", bank);
    end
  endtask

`ifdef SKIP_UNCHANGED_EN
  task automatic test_skip_unchanged();
    do_reset();
    write_word("skip_first", 5'b10110, 1'b0);
    write_word("skip_second", 5'b10011, 1'b0);
  endtask

  task automatic test_skip_zero();
    do_reset();
    write_word("skip_zero", 5'b00000, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_ascending();
    test_descending();
    test_back_to_back();
    test_reset_abort();
`ifdef SKIP_UNCHANGED_EN
    test_skip_unchanged();
    test_skip_zero();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
